zap_wb_walk_arbiter: RTL and testbench

- Two-master Wishbone arbiter directly downstream of the page-walk FSM.
- Merges the page-walker's read-only descriptor fetches (M0) with the cache line-fill/write-back master (M1) onto the single core-side Wishbone bus.
- Grants are registered and held for the whole cycle (CYC high) of the granted master; no preemption.
- Bus signals are a combinational mux of the granted master's registered outputs, so the bus sees no added latency once a grant is held.

---
 rtl/zap_wb_walk_arbiter.sv | 146 ++++++++++++++
 tb/tb_zap_wb_walk_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_walk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zap_wb_walk_arbiter
// Purpose  : Two-master Wishbone arbiter that merges the page walker's
//            read-only descriptor fetches (M0) with the cache line-fill /
//            write-back master (M1) onto the single core-side bus.
//            The grant is registered and is held for the granted master's
//            whole CYC. The bus is a combinational mux of the granted
//            master's registered outputs, so a held grant adds no latency.
// Ports    : i_clk, i_reset       - core clock, synchronous active-high reset
//            i_m0_*  / o_m0_ack   - page-walker master (read only)
//            i_m1_*  / o_m1_ack   - cache master (read/write, bursts)
//            o_wb_*  / i_wb_*     - core-side Wishbone bus
//            o_rd_dat             - read data broadcast to both masters
//            o_grant              - {GNT1, GNT0} one-hot, 00 = idle
// Params   : RR_EN - 1: round-robin on ties, 0: fixed priority (M0 wins)
// Revision : 1.0 - initial release
// ============================================================================
module zap_wb_walk_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // Master 0: page walker
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic [31:0] i_m0_adr,
    input  logic [3:0]  i_m0_sel,
    output logic        o_m0_ack,
    // Master 1: cache
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_wen,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [2:0]  i_m1_cti,
    output logic        o_m1_ack,
    // Shared read data
    output logic [31:0] o_rd_dat,
    // Core-side bus
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,
    // Status
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    // Last master served: 0 = M0, 1 = M1. Only used to break ties in IDLE.
    logic   last_q;
    logic   last_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Only state_q steers the bus mux; master CYC lines affect the next state
    // only, so there is no combinational path from m*_cyc to the grant.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_wb_wen = 1'b0;
        o_wb_sel = 4'h0;
        o_wb_adr = 32'h0;
        o_wb_dat = 32'h0;
        o_wb_cti = 3'b000;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    // Round-robin serves whoever was not served last.
                    state_d = (RR_EN && !last_q) ? GNT1 : GNT0;
                end else if (i_m0_cyc) begin
                    state_d = GNT0;
                end else if (i_m1_cyc) begin
                    state_d = GNT1;
                end
            end

            GNT0: begin
                // Page walker only reads single words: force WE/data/CTI.
                o_wb_cyc = i_m0_cyc;
                o_wb_stb = i_m0_stb;
                o_wb_sel = i_m0_sel;
                o_wb_adr = i_m0_adr;
                o_wb_cti = 3'b111;
                o_m0_ack = i_wb_ack;
                if (!i_m0_cyc) begin
                    last_d  = 1'b0;
                    // Hand straight over to a waiting M1, no idle bubble.
                    state_d = i_m1_cyc ? GNT1 : IDLE;
                end
            end

            GNT1: begin
                // Grant follows CYC, not STB, so bursts with STB gaps
                // keep the bus.
                o_wb_cyc = i_m1_cyc;
                o_wb_stb = i_m1_stb;
                o_wb_wen = i_m1_wen;
                o_wb_sel = i_m1_sel;
                o_wb_adr = i_m1_adr;
                o_wb_dat = i_m1_dat;
                o_wb_cti = i_m1_cti;
                o_m1_ack = i_wb_ack;
                if (!i_m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = i_m0_cyc ? GNT0 : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rd_dat = i_wb_dat;
    assign o_grant  = {state_q == GNT1, state_q == GNT0};

endmodule
`default_nettype wire

// File: tb/tb_zap_wb_walk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zap_wb_walk_arbiter
// Purpose  : Self-checking bench for zap_wb_walk_arbiter. Two instances are
//            driven with the same stimulus: one round-robin, one fixed
//            priority. Each vector row names which instance it checks.
//            Expected rows are queued when driven and popped and compared
//            on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zap_wb_walk_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_cyc, m0_stb;
    logic [31:0] m0_adr;
    logic [3:0]  m0_sel;
    logic        m1_cyc, m1_stb, m1_wen;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat;
    logic [2:0]  m1_cti;
    logic        wb_ack;
    logic [31:0] wb_dat;

    // Outputs of the round-robin instance (r_) and fixed-priority one (f_)
    logic        r_m0_ack, r_m1_ack, r_cyc, r_stb, r_wen;
    logic [3:0]  r_sel;
    logic [31:0] r_adr, r_dat, r_rd;
    logic [2:0]  r_cti;
    logic [1:0]  r_gnt;
    logic        f_m0_ack, f_m1_ack, f_cyc, f_stb, f_wen;
    logic [3:0]  f_sel;
    logic [31:0] f_adr, f_dat, f_rd;
    logic [2:0]  f_cti;
    logic [1:0]  f_gnt;

    zap_wb_walk_arbiter #(.RR_EN(1'b1)) u_rr (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_adr(m0_adr),
        .i_m0_sel(m0_sel), .o_m0_ack(r_m0_ack),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_wen(m1_wen),
        .i_m1_sel(m1_sel), .i_m1_adr(m1_adr), .i_m1_dat(m1_dat),
        .i_m1_cti(m1_cti), .o_m1_ack(r_m1_ack),
        .o_rd_dat(r_rd),
        .o_wb_cyc(r_cyc), .o_wb_stb(r_stb), .o_wb_wen(r_wen),
        .o_wb_sel(r_sel), .o_wb_adr(r_adr), .o_wb_dat(r_dat),
        .o_wb_cti(r_cti), .i_wb_ack(wb_ack), .i_wb_dat(wb_dat),
        .o_grant(r_gnt)
    );

    zap_wb_walk_arbiter #(.RR_EN(1'b0)) u_fp (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_adr(m0_adr),
        .i_m0_sel(m0_sel), .o_m0_ack(f_m0_ack),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_wen(m1_wen),
        .i_m1_sel(m1_sel), .i_m1_adr(m1_adr), .i_m1_dat(m1_dat),
        .i_m1_cti(m1_cti), .o_m1_ack(f_m1_ack),
        .o_rd_dat(f_rd),
        .o_wb_cyc(f_cyc), .o_wb_stb(f_stb), .o_wb_wen(f_wen),
        .o_wb_sel(f_sel), .o_wb_adr(f_adr), .o_wb_dat(f_dat),
        .o_wb_cti(f_cti), .i_wb_ack(wb_ack), .i_wb_dat(wb_dat),
        .o_grant(f_gnt)
    );

    typedef struct {
        int          row;
        logic        fp;
        logic        rst;
        logic        m0c, m0s;
        logic [31:0] m0a;
        logic        m1c, m1s, m1w;
        logic [31:0] m1a;
        logic [2:0]  cti;
        logic        ack;
        logic [31:0] rdat;
        logic [1:0]  g;
        logic        a0, a1;
    } vec_t;

    localparam logic [31:0] A0     = 32'h0000_4008;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;
    localparam logic [31:0] DMASK  = 32'hA5A5_0000;

    vec_t tab_rr[$];
    vec_t tab_fp[$];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic vec_t v(input logic r, input logic m0c, input logic m0s,
                               input logic [31:0] m0a, input logic m1c,
                               input logic m1s, input logic m1w,
                               input logic [31:0] m1a, input logic [2:0] cti,
                               input logic ack, input logic [1:0] g,
                               input logic a0, input logic a1);
        vec_t x;
        x.row = 0; x.fp = 1'b0; x.rst = r;
        x.m0c = m0c; x.m0s = m0s; x.m0a = m0a;
        x.m1c = m1c; x.m1s = m1s; x.m1w = m1w; x.m1a = m1a; x.cti = cti;
        x.ack = ack; x.rdat = 32'h0; x.g = g; x.a0 = a0; x.a1 = a1;
        return x;
    endfunction

    task automatic apply(input vec_t e);
        rst    = e.rst;
        m0_cyc = e.m0c; m0_stb = e.m0s; m0_adr = e.m0a; m0_sel = M0_SEL;
        m1_cyc = e.m1c; m1_stb = e.m1s; m1_wen = e.m1w; m1_sel = M1_SEL;
        m1_adr = e.m1a; m1_dat = e.m1a ^ DMASK; m1_cti = e.cti;
        wb_ack = e.ack;
        e.rdat = $urandom;
        wb_dat = e.rdat;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int row,
                       input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Expected bus bundle {cyc,stb,wen,sel,adr,dat,cti} for a given grant
    function automatic logic [73:0] exp_bus(input vec_t e);
        case (e.g)
            2'b01:   return {e.m0c, e.m0s, 1'b0, M0_SEL, e.m0a, 32'h0, 3'b111};
            2'b10:   return {e.m1c, e.m1s, e.m1w, M1_SEL, e.m1a,
                             e.m1a ^ DMASK, e.cti};
            default: return 74'h0;
        endcase
    endfunction

    vec_t        ck_e;
    logic [73:0] ck_bus;
    logic [1:0]  ck_g;
    logic [1:0]  ck_ack;
    logic [31:0] ck_rd;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            ck_e = sb.pop_front();
            if (ck_e.fp) begin
                ck_bus = {f_cyc, f_stb, f_wen, f_sel, f_adr, f_dat, f_cti};
                ck_g = f_gnt; ck_ack = {f_m1_ack, f_m0_ack}; ck_rd = f_rd;
            end else begin
                ck_bus = {r_cyc, r_stb, r_wen, r_sel, r_adr, r_dat, r_cti};
                ck_g = r_gnt; ck_ack = {r_m1_ack, r_m0_ack}; ck_rd = r_rd;
            end
            chk(ck_e.fp ? "fp_grant" : "rr_grant", ck_e.row, 74'(ck_g), 74'(ck_e.g));
            chk(ck_e.fp ? "fp_acks" : "rr_acks", ck_e.row, 74'(ck_ack),
                74'({ck_e.a1, ck_e.a0}));
            chk(ck_e.fp ? "fp_bus" : "rr_bus", ck_e.row, ck_bus, exp_bus(ck_e));
            chk("rd_dat", ck_e.row, 74'(ck_rd), 74'(ck_e.rdat));
        end
    end

    initial begin
        // Round-robin instance: M0 single read, ties, burst, ack routing, reset
        tab_rr.push_back(v(1,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 0 reset state
        tab_rr.push_back(v(0,1,1,A0,0,0,0,0,     7,0, 2'b00,0,0)); // 1 request seen
        tab_rr.push_back(v(0,1,1,A0,0,0,0,0,     7,0, 2'b01,0,0)); // 2 granted
        tab_rr.push_back(v(0,1,1,A0,0,0,0,0,     7,1, 2'b01,1,0)); // 3 ack
        tab_rr.push_back(v(0,0,0,A0,0,0,0,0,     7,0, 2'b01,0,0)); // 4 release
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 5 idle
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,1, 2'b00,0,0)); // 6 spurious ack
        tab_rr.push_back(v(1,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 7 reset
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h200, 7,0, 2'b00,0,0)); // 8 tie
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h200, 7,0, 2'b01,0,0)); // 9 M0 first
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h200, 7,1, 2'b01,1,0)); // 10
        tab_rr.push_back(v(0,0,0,A0,1,1,0,'h200, 7,0, 2'b01,0,0)); // 11 M0 release
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h200, 7,0, 2'b10,0,0)); // 12 handover
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h200, 7,1, 2'b10,0,1)); // 13
        tab_rr.push_back(v(0,1,1,A0,0,0,0,'h200, 7,0, 2'b10,0,0)); // 14 M1 release
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h200, 7,0, 2'b01,0,0)); // 15 handover
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b01,0,0)); // 16 release
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 17
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h204, 7,0, 2'b00,0,0)); // 18 tie, last=M0
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h204, 7,0, 2'b10,0,0)); // 19 M1 wins
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b10,0,0)); // 20
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 21
        tab_rr.push_back(v(0,0,0,0, 1,1,1,'h100, 2,0, 2'b00,0,0)); // 22 burst req
        tab_rr.push_back(v(0,1,1,A0,1,1,1,'h100, 2,1, 2'b10,0,1)); // 23 beat 0
        tab_rr.push_back(v(0,1,1,A0,1,1,1,'h104, 2,1, 2'b10,0,1)); // 24 beat 1
        tab_rr.push_back(v(0,1,1,A0,1,0,1,'h108, 2,0, 2'b10,0,0)); // 25 stb gap
        tab_rr.push_back(v(0,1,1,A0,1,1,1,'h108, 2,1, 2'b10,0,1)); // 26 beat 2
        tab_rr.push_back(v(0,1,1,A0,1,1,1,'h10C, 7,1, 2'b10,0,1)); // 27 beat 3
        tab_rr.push_back(v(0,1,1,A0,0,0,0,'h10C, 7,0, 2'b10,0,0)); // 28 release
        tab_rr.push_back(v(0,1,1,A0,0,0,0,0,     7,1, 2'b01,1,0)); // 29 M0 next
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b01,0,0)); // 30
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 31
        tab_rr.push_back(v(0,0,0,0, 1,1,0,'h300, 7,1, 2'b00,0,0)); // 32 ack in IDLE
        tab_rr.push_back(v(0,0,0,0, 1,1,0,'h300, 7,0, 2'b10,0,0)); // 33
        tab_rr.push_back(v(0,0,0,0, 1,1,0,'h300, 7,1, 2'b10,0,1)); // 34
        tab_rr.push_back(v(0,0,0,0, 1,1,0,'h300, 7,0, 2'b10,0,0)); // 35
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b10,0,0)); // 36
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,1, 2'b00,0,0)); // 37 ack in IDLE
        tab_rr.push_back(v(0,1,1,A0,0,0,0,0,     7,0, 2'b00,0,0)); // 38
        tab_rr.push_back(v(0,1,1,A0,0,0,0,0,     7,0, 2'b01,0,0)); // 39
        tab_rr.push_back(v(1,1,1,A0,0,0,0,0,     7,1, 2'b01,1,0)); // 40 reset mid-GNT0
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h400, 7,1, 2'b00,0,0)); // 41 dropped
        tab_rr.push_back(v(0,1,1,A0,1,1,0,'h400, 7,0, 2'b01,0,0)); // 42 M0 after reset
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b01,0,0)); // 43
        tab_rr.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 44

        // Fixed-priority instance: M0 wins ties even when it was served last
        tab_fp.push_back(v(1,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 0
        tab_fp.push_back(v(0,1,1,A0,1,1,0,'h500, 7,0, 2'b00,0,0)); // 1
        tab_fp.push_back(v(0,1,1,A0,1,1,0,'h500, 7,0, 2'b01,0,0)); // 2
        tab_fp.push_back(v(0,0,0,A0,0,0,0,'h500, 7,0, 2'b01,0,0)); // 3 both drop
        tab_fp.push_back(v(0,1,1,A0,1,1,0,'h500, 7,0, 2'b00,0,0)); // 4 tie, last=M0
        tab_fp.push_back(v(0,1,1,A0,1,1,0,'h500, 7,1, 2'b01,1,0)); // 5 M0 again
        tab_fp.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b01,0,0)); // 6
        tab_fp.push_back(v(0,1,1,A0,1,1,0,'h504, 7,0, 2'b00,0,0)); // 7
        tab_fp.push_back(v(0,1,1,A0,1,1,0,'h504, 7,0, 2'b01,0,0)); // 8
        tab_fp.push_back(v(0,0,0,A0,1,1,0,'h504, 7,0, 2'b01,0,0)); // 9 handover
        tab_fp.push_back(v(0,0,0,0, 1,1,0,'h504, 7,1, 2'b10,0,1)); // 10
        tab_fp.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b10,0,0)); // 11
        tab_fp.push_back(v(0,0,0,0, 0,0,0,0,     7,0, 2'b00,0,0)); // 12

        rst = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_adr = '0; m0_sel = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_wen = 1'b0; m1_sel = '0;
        m1_adr = '0; m1_dat = '0; m1_cti = '0;
        wb_ack = 1'b0; wb_dat = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tab_rr.size(); i++) begin
            vec_t e;
            e = tab_rr[i];
            e.row = i;
            e.fp  = 1'b0;
            apply(e);
        end
        for (int i = 0; i < tab_fp.size(); i++) begin
            vec_t e;
            e = tab_fp[i];
            e.row = 100 + i;
            e.fp  = 1'b1;
            apply(e);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
